fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch front end for the RISC-V core. It replaces the fixed PC + 4 loop with a decoupled fetch stage: it owns the fetch PC, issues pipelined word requests to instruction memory under a valid/ready handshake, and buffers in-order responses in a DEPTH-entry queue. It presents {pc, instr} pairs to decode under valid/ready and supports redirect, which flushes the queue and discards in-flight responses, for branches, jumps and traps.

## Interface
- XLEN, 32: address and instruction width.
- DEPTH, 4: queue entries and maximum outstanding IMEM requests. Power of two, ≥ 2.
- RESET_PC, 32'h0000_0000: fetch PC after reset.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  one clock; reset is synchronous and active-high.
- imem_req_valid  out  1  request address valid.
- imem_req_ready  in  1  IMEM accepts the request this cycle.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_resp_valid  in  1  response data valid. Always accepted; no ready.
- imem_resp_data  in  XLEN  instruction word.
- redirect_valid  in  1  redirect the fetch stream.
- redirect_pc  in  XLEN  new fetch PC; bits [1:0] are forced to 0.
- if_valid  out  1  head entry holds a returned instruction.
- if_ready  in  1  decode consumes the head.
- if_pc  out  XLEN  PC of the head instruction.
- if_instr  out  XLEN  head instruction.

## Operation
- State:
  - fetch_pc.
  - Circular queue of DEPTH entries {pc, instr, filled}, with alloc, fill and head pointers and a count.
  - drop_cnt: responses still owed for flushed requests.
- Issue:
  - imem_req_valid = !rst && !redirect_valid && (count + drop_cnt < DEPTH).
  - imem_req_addr = fetch_pc.
  - On handshake: allocate the entry at alloc with pc = fetch_pc and filled = 0, then fetch_pc += 4.
  - Address arithmetic wraps modulo 2^XLEN.
- Response:
  - If drop_cnt > 0, discard the response and decrement drop_cnt.
  - Otherwise write the instruction into the entry at fill, set filled, and advance fill.
  - Responses are in request order and arrive no earlier than the cycle after their request.
- Output:
  - if_valid = head entry filled.
  - On if_valid && if_ready, pop the head.
- Redirect, which takes priority over everything in its cycle:
  - Empty the queue.
  - drop_cnt_next = drop_cnt + unfilled entries − (imem_resp_valid ? 1 : 0).
  - fetch_pc = redirect_pc & ~3.
  - Issue nothing that cycle; requests resume the next cycle from the new PC.
  - A concurrent if handshake still completes; decode sees that instruction.
- Count update: count_next = count + alloc − pop. This is exact under simultaneous alloc and pop, including when full and popping (no alloc, since credit is checked on current state).
- Pointer width is log2(DEPTH); pointers wrap naturally.

## Timing
- Reset values:
  - imem_req_valid = 0, if_valid = 0.
  - fetch_pc = RESET_PC.
  - count = drop_cnt = 0, all pointers = 0.
  - if_pc and if_instr = 0.
- The first request is presented in the first cycle after rst deasserts.
- Latency:
  - A response captured at edge N is visible at if_valid in cycle N+1.
  - An empty-queue fetch costs 1 cycle for the request, plus IMEM latency, plus 1 cycle.
- Throughput: one request per cycle sustained while credit remains.
- imem_req_valid and imem_req_addr may change without a handshake only on redirect, or when credit is exhausted.
- rst mid-operation:
  - All state is cleared, including drop_cnt.
  - The surrounding design must reset IMEM on the same edge, so no stale responses arrive.
- Boundaries:
  - count + drop_cnt == DEPTH: no issue.
  - Head unfilled: if_valid = 0.
  - drop_cnt never exceeds DEPTH.

## Structure
- Shared package core_pkg holds:
  - XLEN.
  - RESET_PC default.
  - Instruction-word step (4).
  - Typedef fetch_entry_t {pc, instr, filled}.
- One sub-module: fetch_queue, the DEPTH-entry in-order allocate/fill/pop buffer with flush.
- Fetch PC, credit and drop logic stay in fetch_unit.
- core instantiates fetch_unit in place of its pc register and PC + 4 adder.

## Test plan
- Reset, IMEM 1-cycle latency, if_ready = 1:
  - Addresses 0x0, 0x4, 0x8 … are issued back-to-back.
  - if_pc/if_instr pairs match, in order, one per cycle after 2-cycle fill.
- if_ready = 0 with DEPTH = 4:
  - Exactly 4 requests are issued, then imem_req_valid = 0.
  - Releasing if_ready resumes one issue per popped entry.
- Redirect to 0x103 with 3 requests outstanding and 1 response arriving that cycle:
  - drop_cnt = 2; the next 2 responses are discarded.
  - The next issued address is 0x100; if_pc is 0x100 first.
- Redirect simultaneous with an if handshake at pc 0x8: 0x8 is consumed, the remaining queue is flushed, and nothing from the old stream appears afterwards.
- fetch_pc 0xFFFF_FFFC with IMEM stalling via imem_req_ready = 0 for 3 cycles:
  - Address is held stable.
  - After acceptance, the next address wraps to 0x0000_0000.
- rst asserted mid-stream with a full queue: next cycle if_valid = 0, imem_req_valid = 0; then fetch restarts at RESET_PC.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, reset PC, fetch step and queue entry type.
package core_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;
  localparam int unsigned INSTR_STEP = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: IMEM request/response, redirect and the decode-facing handshake.
interface fetch_unit_if #(
  parameter int unsigned XLEN = core_pkg::XLEN
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
    input  if_ready
  );

  // Memory / decode / redirect source side.
  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
    output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
    output if_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// In-order fetch buffer: entries are allocated at request time, filled as responses return
// and popped by decode. Flush empties the buffer in one cycle.
module fetch_queue import core_pkg::*; #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CntW  = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [XLEN-1:0] fill_data,
  input  logic            pop,
  output logic [CntW-1:0] count,
  output logic [CntW-1:0] pending,
  output fetch_entry_t    head
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  fetch_entry_t    entries_q [DEPTH];
  logic [PtrW-1:0] alloc_ptr_q, fill_ptr_q, head_ptr_q;
  logic [CntW-1:0] count_q, pend_q;

  assign count   = count_q;
  assign pending = pend_q;
  assign head    = entries_q[head_ptr_q];

  // Pointer, occupancy and storage update; alloc/fill/pop never target the same entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      pend_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else if (flush) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      pend_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) entries_q[i].filled <= 1'b0;
    end else begin
      if (alloc) begin
        entries_q[alloc_ptr_q].pc     <= alloc_pc;
        entries_q[alloc_ptr_q].filled <= 1'b0;
        alloc_ptr_q                   <= alloc_ptr_q + PtrW'(1);
      end
      if (fill) begin
        entries_q[fill_ptr_q].instr  <= fill_data;
        entries_q[fill_ptr_q].filled <= 1'b1;
        fill_ptr_q                   <= fill_ptr_q + PtrW'(1);
      end
      if (pop) begin
        entries_q[head_ptr_q].filled <= 1'b0;
        head_ptr_q                   <= head_ptr_q + PtrW'(1);
      end
      count_q <= count_q + CntW'(alloc) - CntW'(pop);
      pend_q  <= pend_q + CntW'(alloc) - CntW'(fill);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: owns the fetch PC, issues pipelined IMEM requests against a
// credit of queue slots plus owed-but-flushed responses, and handles redirects.
module fetch_unit import core_pkg::*; #(
  parameter int unsigned     XLEN     = core_pkg::XLEN,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0] count, pending;
  logic [CntW:0]   inflight;
  fetch_entry_t    head;
  logic            alloc, fill, pop;

  // Credit covers queued entries and responses still owed for flushed requests.
  assign inflight           = {1'b0, count} + {1'b0, drop_cnt_q};
  assign bus.imem_req_valid = !rst && !bus.redirect_valid && (inflight < (CntW + 1)'(DEPTH));
  assign bus.imem_req_addr  = fetch_pc_q;

  assign alloc = bus.imem_req_valid && bus.imem_req_ready;
  assign fill  = bus.imem_resp_valid && !bus.redirect_valid && (drop_cnt_q == '0);
  assign pop   = head.filled && bus.if_ready;

  assign bus.if_valid = head.filled;
  assign bus.if_pc    = head.pc;
  assign bus.if_instr = head.instr;

  // Next fetch PC and drop count; redirect wins over issue and response bookkeeping.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ~XLEN'(3);
      // Every unfilled entry is now owed; a response arriving this cycle pays one back.
      drop_cnt_d = drop_cnt_q + pending - CntW'(bus.imem_resp_valid);
    end else begin
      if (alloc) fetch_pc_d = fetch_pc_q + XLEN'(INSTR_STEP);
      if (bus.imem_resp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CntW'(1);
    end
  end

  // Fetch PC and drop count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .CntW  (CntW)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .alloc     (alloc),
    .alloc_pc  (fetch_pc_q),
    .fill      (fill),
    .fill_data (bus.imem_resp_data),
    .pop       (pop),
    .count     (count),
    .pending   (pending),
    .head      (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: per-cycle vector table plus an IMEM model and an
// in-order scoreboard of expected {pc, instr} pairs.
module tb_fetch_unit;
  import core_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned NVEC  = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(32)) bus ();

  fetch_unit #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    bit          filled;
  } sb_t;

  typedef struct {
    bit          rr;
    bit          ir;
    bit          re;
    bit          exp_rv;
    logic [31:0] exp_addr;
    bit          exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  sb_t         exp_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] exp_addr;
  int unsigned m_drop;
  int unsigned n_issued;
  bit          model_on, vec_on, resp_en, pop_seen;
  logic [31:0] last_pop_pc;
  vec_t        vecs[NVEC];
  vec_t        cur;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference behaviour for one cycle, evaluated with the cycle's inputs and outputs stable.
  task automatic model();
    bit          rv_exp, iv_exp, found;
    int unsigned unf;
    rv_exp = !rst && !bus.redirect_valid && (exp_q.size() + m_drop < DEPTH);
    iv_exp = (exp_q.size() > 0) && exp_q[0].filled;
    chk("req_valid", {31'b0, bus.imem_req_valid}, {31'b0, rv_exp});
    if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, exp_addr);
    chk("if_valid", {31'b0, bus.if_valid}, {31'b0, iv_exp});
    if (iv_exp && bus.if_ready) begin
      chk("if_pc", bus.if_pc, exp_q[0].pc);
      chk("if_instr", bus.if_instr, instr_of(exp_q[0].pc));
      last_pop_pc = exp_q[0].pc;
      pop_seen    = 1'b1;
      void'(exp_q.pop_front());
    end
    if (rst) begin
      exp_q.delete();
      m_drop   = 0;
      exp_addr = 32'h0;
    end else if (bus.redirect_valid) begin
      unf = 0;
      foreach (exp_q[i]) if (!exp_q[i].filled) unf++;
      m_drop = m_drop + unf - (bus.imem_resp_valid ? 1 : 0);
      exp_q.delete();
      exp_addr = bus.redirect_pc & ~32'h3;
    end else begin
      if (bus.imem_resp_valid) begin
        if (m_drop > 0) m_drop--;
        else begin
          found = 1'b0;
          foreach (exp_q[i]) begin
            if (!found && !exp_q[i].filled) begin
              exp_q[i].filled = 1'b1;
              found = 1'b1;
            end
          end
        end
      end
      if (rv_exp && bus.imem_req_ready) begin
        exp_q.push_back('{pc: exp_addr, filled: 1'b0});
        exp_addr = exp_addr + 32'd4;
      end
    end
  endtask

  // One clock: sample at the falling edge, then update the IMEM response after the rising edge.
  task automatic step();
    @(negedge clk);
    if (vec_on) begin
      chk("vec_req_valid", {31'b0, bus.imem_req_valid}, {31'b0, cur.exp_rv});
      if (cur.exp_rv) chk("vec_req_addr", bus.imem_req_addr, cur.exp_addr);
      chk("vec_if_valid", {31'b0, bus.if_valid}, {31'b0, cur.exp_iv});
      if (cur.exp_iv) begin
        chk("vec_if_pc", bus.if_pc, cur.exp_pc);
        chk("vec_if_instr", bus.if_instr, instr_of(cur.exp_pc));
      end
    end
    if (model_on) model();
    if (!rst && bus.imem_req_valid && bus.imem_req_ready) begin
      mem_q.push_back(bus.imem_req_addr);
      n_issued++;
    end
    if (rst) mem_q.delete();
    @(posedge clk);
    #1;
    if (resp_en && mem_q.size() > 0) begin
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = instr_of(mem_q.pop_front());
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;
    end
  endtask

  task automatic set_in(input bit rr, input bit ir, input bit re);
    bus.imem_req_ready = rr;
    bus.if_ready       = ir;
    resp_en            = re;
  endtask

  task automatic drain();
    set_in(1'b0, 1'b1, 1'b1);
    repeat (8) step();
  endtask

  task automatic wait_pop(input string nm, input logic [31:0] exp_pc);
    pop_seen = 1'b0;
    for (int k = 0; k < 16 && !pop_seen; k++) step();
    chk({nm, "_seen"}, {31'b0, pop_seen}, 32'h1);
    chk(nm, last_pop_pc, exp_pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    // Stream from reset (1-cycle IMEM), then decode stall fills the queue, then release.
    vecs[0]  = '{1, 1, 1, 1, 32'h00, 0, 32'h00};
    vecs[1]  = '{1, 1, 1, 1, 32'h04, 0, 32'h00};
    vecs[2]  = '{1, 1, 1, 1, 32'h08, 1, 32'h00};
    vecs[3]  = '{1, 1, 1, 1, 32'h0C, 1, 32'h04};
    vecs[4]  = '{1, 1, 1, 1, 32'h10, 1, 32'h08};
    vecs[5]  = '{1, 1, 1, 1, 32'h14, 1, 32'h0C};
    vecs[6]  = '{1, 0, 1, 1, 32'h18, 1, 32'h10};
    vecs[7]  = '{1, 0, 1, 1, 32'h1C, 1, 32'h10};
    vecs[8]  = '{1, 0, 1, 0, 32'h00, 1, 32'h10};
    vecs[9]  = '{1, 0, 1, 0, 32'h00, 1, 32'h10};
    vecs[10] = '{1, 1, 1, 0, 32'h00, 1, 32'h10};
    vecs[11] = '{1, 1, 1, 1, 32'h20, 1, 32'h14};
    vecs[12] = '{1, 1, 1, 1, 32'h24, 1, 32'h18};
    vecs[13] = '{1, 1, 1, 1, 32'h28, 1, 32'h1C};
    vecs[14] = '{1, 1, 1, 1, 32'h2C, 1, 32'h20};

    rst                 = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    set_in(1'b1, 1'b1, 1'b1);
    model_on = 1'b0;
    vec_on   = 1'b0;
    m_drop   = 0;
    n_issued = 0;
    exp_addr = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    chk("rst_if_valid", {31'b0, bus.if_valid}, 32'h0);
    chk("rst_if_pc", bus.if_pc, 32'h0);
    chk("rst_if_instr", bus.if_instr, 32'h0);
    chk("rst_req_addr", bus.imem_req_addr, 32'h0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    model_on = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      cur    = vecs[i];
      set_in(cur.rr, cur.ir, cur.re);
      vec_on = 1'b1;
      step();
    end
    vec_on = 1'b0;

    // Credit limit from an empty queue with decode stalled.
    drain();
    set_in(1'b1, 1'b0, 1'b1);
    n_issued = 0;
    repeat (8) step();
    chk("credit_issue_count", n_issued, 32'd4);
    chk("credit_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);

    // Redirect with 3 outstanding and one response landing in the redirect cycle.
    drain();
    set_in(1'b1, 1'b0, 1'b0);
    repeat (3) step();
    set_in(1'b0, 1'b0, 1'b1);
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    step();
    bus.redirect_valid = 1'b0;
    chk("redirect_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
    chk("redirect_next_addr", bus.imem_req_addr, 32'h0000_0100);
    set_in(1'b1, 1'b1, 1'b1);
    wait_pop("redirect_first_pc", 32'h0000_0100);

    // Redirect coinciding with the decode handshake of pc 0x8.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0;
    step();
    bus.redirect_valid = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      if (exp_q.size() > 0 && exp_q[0].filled && exp_q[0].pc == 32'h8) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        pop_seen           = 1'b0;
        step();
        bus.redirect_valid = 1'b0;
        hit                = 1'b1;
      end else begin
        step();
      end
    end
    chk("redir_pop_hit", {31'b0, hit}, 32'h1);
    chk("redir_pop_pc", last_pop_pc, 32'h8);
    wait_pop("redir_pop_next_pc", 32'h0000_0200);

    // Address wrap with IMEM refusing the request for 3 cycles.
    set_in(1'b0, 1'b1, 1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFE;
    step();
    bus.redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("wrap_hold_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    end
    set_in(1'b1, 1'b1, 1'b1);
    n_issued = 0;
    for (int k = 0; k < 8 && n_issued == 0; k++) step();
    chk("wrap_accepted", n_issued, 32'd1);
    chk("wrap_next_addr", bus.imem_req_addr, 32'h0000_0000);
    wait_pop("wrap_first_pc", 32'hFFFF_FFFC);

    // Reset mid-stream with a full queue.
    set_in(1'b1, 1'b0, 1'b1);
    repeat (8) step();
    chk("full_if_valid", {31'b0, bus.if_valid}, 32'h1);
    rst = 1'b1;
    step();
    chk("midrst_if_valid", {31'b0, bus.if_valid}, 32'h0);
    chk("midrst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
    chk("midrst_drop_cnt", 32'(dut.drop_cnt_q), 32'd0);
    rst = 1'b0;
    #1;
    chk("restart_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
    chk("restart_req_addr", bus.imem_req_addr, 32'h0);
    set_in(1'b1, 1'b1, 1'b1);
    wait_pop("restart_first_pc", 32'h0);
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
